// File: rtl/rect_fill_pkg.sv
// Shared types and constants for the rect_fill solid-rectangle engine.
package rect_fill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_REQ    = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } rect_fill_state_t;

  typedef logic [15:0] coord_t;

  localparam int VRAM_ADDR_W = 24;

  // Colour word layout: {4'h0, R[3:0], G[3:0], B[3:0]}
  localparam int COLOR_FIELD_W = 4;
  localparam int COLOR_B_LSB   = 0;
  localparam int COLOR_G_LSB   = 4;
  localparam int COLOR_R_LSB   = 8;

endpackage

// File: rtl/rect_fill.sv
// Solid-rectangle fill engine driving the framebuffer's single-word VRAM write port.
// Build option: RECT_FILL_CLIP_EN clamps rectangles to the framebuffer instead of rejecting them.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a command; latch fields on cmd_valid_i
// SETUP     | apply range policy, load counters, register y0*FB_WIDTH
// REQ       | write request held until vram_ack_i
// NEXT      | advance to next pixel / row, or finish
// FINISH    | one-cycle done_o (or err_o when rejected)
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int          FB_WIDTH  = 640,
  parameter int          FB_HEIGHT = 480,
  parameter logic [23:0] BASE_ADDR = 24'h0
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_x0_i,
  input  logic [15:0] cmd_y0_i,
  input  logic [15:0] cmd_x1_i,
  input  logic [15:0] cmd_y1_i,
  input  logic [15:0] cmd_color_i,
  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [3:0]  vram_mask_o,
  output logic [31:0] vram_addr_o,
  output logic [15:0] vram_data_out_o,
  input  logic        vram_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam coord_t                  X_MAX    = coord_t'(FB_WIDTH - 1);
  localparam coord_t                  Y_MAX    = coord_t'(FB_HEIGHT - 1);
  localparam logic [VRAM_ADDR_W-1:0]  ROW_STEP = VRAM_ADDR_W'(FB_WIDTH);
  localparam logic [31:0]             ROW_MUL  = 32'(FB_WIDTH);

  rect_fill_state_t state_q, state_d;
  coord_t x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  coord_t cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [15:0] color_q, color_d;
  logic [VRAM_ADDR_W-1:0] row_base_q, row_base_d;
  logic err_q, err_d;

  logic setup_empty;
  logic setup_reject;
  logic [31:0] row_prod;
  logic [VRAM_ADDR_W-1:0] pix_addr;

  assign row_prod = {16'h0, y0_q} * ROW_MUL;
  assign pix_addr = BASE_ADDR + row_base_q + {8'h0, cur_x_q};

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    color_d      = color_q;
    row_base_d   = row_base_q;
    err_d        = err_q;
    setup_empty  = 1'b0;
    setup_reject = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          x0_d    = cmd_x0_i;
          y0_d    = cmd_y0_i;
          x1_d    = cmd_x1_i;
          y1_d    = cmd_y1_i;
          color_d = cmd_color_i;
          err_d   = 1'b0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
`ifdef RECT_FILL_CLIP_EN
        x1_d         = (x1_q > X_MAX) ? X_MAX : x1_q;
        y1_d         = (y1_q > Y_MAX) ? Y_MAX : y1_q;
        setup_reject = 1'b0;
        setup_empty  = (x0_q > X_MAX) || (y0_q > Y_MAX) ||
                       (x0_q > x1_d) || (y0_q > y1_d);
`else
        setup_reject = (x0_q > X_MAX) || (x1_q > X_MAX) ||
                       (y0_q > Y_MAX) || (y1_q > Y_MAX);
        setup_empty  = setup_reject || (x0_q > x1_q) || (y0_q > y1_q);
`endif
        err_d = setup_reject;
        if (setup_empty) begin
          state_d = ST_FINISH;
        end else begin
          cur_x_d    = x0_q;
          cur_y_d    = y0_q;
          row_base_d = row_prod[VRAM_ADDR_W-1:0];
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        if (vram_ack_i) state_d = ST_NEXT;
      end

      ST_NEXT: begin
        // x1/y1 are already clamped to the framebuffer, so counters never wrap
        if (cur_x_q < x1_q) begin
          cur_x_d = cur_x_q + 16'd1;
          state_d = ST_REQ;
        end else if (cur_y_q < y1_q) begin
          cur_x_d    = x0_q;
          cur_y_d    = cur_y_q + 16'd1;
          row_base_d = row_base_q + ROW_STEP;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      color_q    <= '0;
      row_base_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      color_q    <= color_d;
      row_base_q <= row_base_d;
      err_q      <= err_d;
    end
  end

  // Ready is held low while reset is asserted, not just after the reset edge
  assign cmd_ready_o     = (state_q == ST_IDLE) && reset_n_i;
  assign busy_o          = (state_q != ST_IDLE);
  assign vram_sel_o      = (state_q == ST_REQ);
  assign vram_wr_o       = vram_sel_o;
  assign vram_mask_o     = vram_sel_o ? 4'b1111 : 4'b0000;
  assign vram_addr_o     = vram_sel_o ? {8'h00, pix_addr} : 32'h0;
  assign vram_data_out_o = vram_sel_o ? color_q : 16'h0;
  assign done_o          = (state_q == ST_FINISH) && !err_q;
`ifdef RECT_FILL_CLIP_EN
  assign err_o           = 1'b0;
`else
  assign err_o           = (state_q == ST_FINISH) && err_q;
`endif

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: directed corner cases plus randomized rectangles vs. a pixel-list model.
module tb_rect_fill;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [15:0] cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i, cmd_color_i;
  logic        vram_sel_o, vram_wr_o;
  logic [3:0]  vram_mask_o;
  logic [31:0] vram_addr_o;
  logic [15:0] vram_data_out_o;
  logic        vram_ack_i;
  logic        busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  bit exp_err;

  always #5 clk = ~clk;

  rect_fill #(.FB_WIDTH(W), .FB_HEIGHT(H), .BASE_ADDR(24'h0)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i(cmd_x0_i), .cmd_y0_i(cmd_y0_i), .cmd_x1_i(cmd_x1_i), .cmd_y1_i(cmd_y1_i),
    .cmd_color_i(cmd_color_i),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
    .vram_addr_o(vram_addr_o), .vram_data_out_o(vram_data_out_o), .vram_ack_i(vram_ack_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Expected pixel addresses in row-major order, straight from the range policy.
  task automatic build_model(input int x0, input int y0, input int x1, input int y1);
    int ex1, ey1;
    exp_q.delete();
    exp_err = 1'b0;
`ifdef RECT_FILL_CLIP_EN
    ex1 = (x1 > W - 1) ? W - 1 : x1;
    ey1 = (y1 > H - 1) ? H - 1 : y1;
`else
    if (x0 >= W || x1 >= W || y0 >= H || y1 >= H) begin
      exp_err = 1'b1;
      return;
    end
    ex1 = x1;
    ey1 = y1;
`endif
    for (int y = y0; y <= ey1; y++)
      for (int x = x0; x <= ex1; x++)
        exp_q.push_back((y * W + x) % (1 << 24));
  endtask

  // delay >= 0: fixed ack wait per request; delay < 0: random wait and random ack noise outside REQ.
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input logic [15:0] col, input int delay, input bit junk, input string name);
    int cyc, last_ack, req_wait, nw, budget;
    bit finished;
    build_model(x0, y0, x1, y1);
    nw = exp_q.size();
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s ready_before_cmd: got %b want 1", name, cmd_ready_o);
    end
    cmd_valid_i = 1'b1;
    cmd_x0_i = 16'(x0); cmd_y0_i = 16'(y0); cmd_x1_i = 16'(x1); cmd_y1_i = 16'(y1);
    cmd_color_i = col;
    @(negedge clk);
    cmd_valid_i = junk;
    if (junk) begin
      cmd_x0_i = 16'($urandom_range(0, 20)); cmd_y0_i = 16'($urandom_range(0, 20));
      cmd_x1_i = 16'($urandom_range(21, 40)); cmd_y1_i = 16'($urandom_range(21, 40));
      cmd_color_i = ~col;
    end
    last_ack = -10;
    req_wait = -1;
    finished = 1'b0;
    budget = nw * 10 + 20;
    for (cyc = 1; cyc <= budget && !finished; cyc++) begin
      if (cyc > 1) @(negedge clk);
      checks++;
      if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
        errors++; $display("FAIL %s busy c%0d: busy=%b ready=%b want 1/0", name, cyc, busy_o, cmd_ready_o);
      end
      if (cyc == 1) begin
        checks++;
        if (vram_sel_o !== 1'b0) begin
          errors++; $display("FAIL %s setup_sel: got %b want 0", name, vram_sel_o);
        end
      end
      if (cyc == 2 && nw > 0) begin
        checks++;
        if (vram_sel_o !== 1'b1) begin
          errors++; $display("FAIL %s first_req_latency: sel=%b want 1", name, vram_sel_o);
        end
      end
      if (cyc == last_ack + 1) begin
        checks++;
        if (vram_sel_o !== 1'b0) begin
          errors++; $display("FAIL %s gap_after_ack c%0d: sel=%b want 0", name, cyc, vram_sel_o);
        end
      end
      if (cyc == last_ack + 2 && exp_q.size() > 0) begin
        checks++;
        if (vram_sel_o !== 1'b1) begin
          errors++; $display("FAIL %s next_req c%0d: sel=%b want 1", name, cyc, vram_sel_o);
        end
      end
      if (vram_sel_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_write: addr=%0d want none", name, vram_addr_o);
          vram_ack_i = 1'b1;
          req_wait = -1;
        end else begin
          if (vram_addr_o !== 32'(exp_q[0]) || vram_data_out_o !== col ||
              vram_mask_o !== 4'hF || vram_wr_o !== 1'b1) begin
            errors++;
            $display("FAIL %s write c%0d: addr=%0d data=%h mask=%h wr=%b want addr=%0d data=%h mask=f wr=1",
                     name, cyc, vram_addr_o, vram_data_out_o, vram_mask_o, vram_wr_o, exp_q[0], col);
          end
          if (req_wait < 0) req_wait = (delay >= 0) ? delay : int'($urandom_range(0, 3));
          if (req_wait == 0) begin
            vram_ack_i = 1'b1;
            void'(exp_q.pop_front());
            last_ack = cyc;
            req_wait = -1;
          end else begin
            vram_ack_i = 1'b0;
            req_wait--;
          end
        end
      end else begin
        checks++;
        if (vram_wr_o !== 1'b0 || vram_mask_o !== 4'h0) begin
          errors++; $display("FAIL %s idle_strobe: wr=%b mask=%h want 0/0", name, vram_wr_o, vram_mask_o);
        end
        vram_ack_i = (delay < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (done_o === 1'b1 || err_o === 1'b1) begin
        finished = 1'b1;
        checks++;
        if (done_o !== !exp_err || err_o !== exp_err) begin
          errors++; $display("FAIL %s end_kind: done=%b err=%b want %b/%b", name, done_o, err_o, !exp_err, exp_err);
        end
        checks++;
        if (exp_q.size() != 0) begin
          errors++; $display("FAIL %s missing_writes: left=%0d want 0", name, exp_q.size());
        end
        checks++;
        if (cyc != ((nw > 0) ? last_ack + 2 : 2)) begin
          errors++; $display("FAIL %s end_timing: cycle=%0d want %0d", name, cyc, (nw > 0) ? last_ack + 2 : 2);
        end
      end
    end
    cmd_valid_i = 1'b0;
    vram_ack_i = 1'b0;
    if (!finished) begin
      errors++; checks++;
      $display("FAIL %s timeout: no done/err within %0d cycles", name, budget);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL %s after_end: ready=%b busy=%b done=%b err=%b want 1/0/0/0",
                         name, cmd_ready_o, busy_o, done_o, err_o);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b0 || busy_o !== 1'b0 || vram_sel_o !== 1'b0 || vram_wr_o !== 1'b0 ||
        vram_mask_o !== 4'h0 || vram_addr_o !== 32'h0 || vram_data_out_o !== 16'h0 ||
        done_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: ready=%b busy=%b sel=%b done=%b err=%b want all 0",
                         cmd_ready_o, busy_o, vram_sel_o, done_o, err_o);
    end
    reset_n_i = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b busy=%b want 1/0", cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_reset_abort();
    int n_req;
    bit prev_sel, hit;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_x0_i = 16'd0; cmd_y0_i = 16'd3; cmd_x1_i = 16'd9; cmd_y1_i = 16'd3;
    cmd_color_i = 16'h0ABC;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    n_req = 0; prev_sel = 1'b0; hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (c > 0) @(negedge clk);
      if (vram_sel_o === 1'b1 && !prev_sel) n_req++;
      prev_sel = vram_sel_o;
      if (vram_sel_o === 1'b1 && n_req == 3) begin
        hit = 1'b1;
        checks++;
        if (vram_addr_o !== 32'd1922) begin
          errors++; $display("FAIL abort_third_addr: got %0d want 1922", vram_addr_o);
        end
        vram_ack_i = 1'b0;
        reset_n_i = 1'b0;
      end else begin
        vram_ack_i = vram_sel_o;
      end
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL abort_reach_third: requests=%0d want 3", n_req);
    end
    vram_ack_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (vram_sel_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
        errors++; $display("FAIL abort_in_reset c%0d: sel=%b done=%b busy=%b ready=%b want 0/0/0/0",
                           c, vram_sel_o, done_o, busy_o, cmd_ready_o);
      end
    end
    reset_n_i = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL abort_release: ready=%b done=%b want 1/0", cmd_ready_o, done_o);
    end
    run_cmd(1, 0, 3, 1, 16'h0123, 0, 1'b0, "after_abort");
  endtask

  task automatic test_basic();
    run_cmd(2, 1, 4, 2, 16'h0F00, 0, 1'b0, "basic_fast");
  endtask

  task automatic test_ack_delay();
    run_cmd(2, 1, 4, 2, 16'h0F00, 5, 1'b0, "basic_delay5");
  endtask

  task automatic test_corners();
    run_cmd(639, 479, 639, 479, 16'h0FFF, 0, 1'b0, "last_pixel");
    run_cmd(630, 0, 700, 0, 16'h00F0, 1, 1'b0, "clip_or_reject");
    run_cmd(5, 5, 3, 5, 16'h0555, 0, 1'b0, "empty_rect");
    run_cmd(0, 600, 2, 601, 16'h0111, 0, 1'b0, "y_out_of_range");
  endtask

  task automatic test_back_to_back();
    run_cmd(10, 20, 12, 21, 16'h0321, 0, 1'b1, "busy_valid_1");
    run_cmd(100, 7, 101, 9, 16'h0654, 2, 1'b1, "busy_valid_2");
  endtask

  task automatic test_random();
    int x0, y0, x1, y1;
    for (int i = 0; i < 25; i++) begin
      x0 = $urandom_range(0, 645);
      y0 = $urandom_range(0, 484);
      x1 = x0 + $urandom_range(0, 5) - (($urandom_range(0, 7) == 0) ? 3 : 0);
      y1 = y0 + $urandom_range(0, 3) - (($urandom_range(0, 7) == 0) ? 2 : 0);
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      run_cmd(x0, y0, x1, y1, 16'($urandom_range(0, 16'hFFFF)), -1, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    reset_n_i   = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_x0_i = '0; cmd_y0_i = '0; cmd_x1_i = '0; cmd_y1_i = '0;
    cmd_color_i = '0;
    vram_ack_i  = 1'b0;
    test_reset();
    test_basic();
    test_ack_delay();
    test_corners();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/rect_fill.md
# rect_fill

Solid-rectangle fill engine that drives the framebuffer's single-word VRAM access port (sel/wr/ack handshake) in place of the test-pattern generator. It accepts one rectangle command at a time: inclusive corners and a 16-bit colour. It then emits one VRAM write per covered pixel, row-major, and pulses completion. It sits upstream of the framebuffer, on the pixel clock.

## Interface
Parameters:
- FB_WIDTH, 640, framebuffer width in pixels
- FB_HEIGHT, 480, framebuffer height in pixels
- BASE_ADDR, 24'h0, word address of pixel (0,0)

Ports:
- clk  in  1  pixel clock; the only clock
- reset_n_i  in  1  synchronous, active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  engine can accept a command
- cmd_x0_i, cmd_y0_i  in  16 each  top-left corner, unsigned, inclusive
- cmd_x1_i, cmd_y1_i  in  16 each  bottom-right corner, unsigned, inclusive
- cmd_color_i  in  16  pixel value, format {4'h0, R[3:0], G[3:0], B[3:0]}
- vram_sel_o  out  1  VRAM request
- vram_wr_o  out  1  write strobe; equals vram_sel_o
- vram_mask_o  out  4  byte mask; 4'b1111 whenever vram_sel_o=1, else 0
- vram_addr_o  out  32  word address; bits [31:24] are 0
- vram_data_out_o  out  16  write data
- vram_ack_i  in  1  framebuffer acknowledge, one-cycle pulse
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle pulse at command end
- err_o  out  1  one-cycle pulse when a command is rejected (only without clipping)

## Operation
- States: IDLE, SETUP, REQ, NEXT, FINISH.
- **IDLE:** cmd_ready_o=1. When cmd_valid_i=1, latch all cmd fields and go to SETUP.
- **SETUP (one cycle):**
  - Apply the range policy (see Configuration).
  - Empty rectangle (x0>x1 or y0>y1 after policy): go to FINISH with no writes.
  - Otherwise set cur_x=x0, cur_y=y0, row_base=y0*FB_WIDTH (24-bit), then go to REQ.
- **REQ:**
  - vram_sel_o=vram_wr_o=1.
  - vram_addr_o = BASE_ADDR + row_base + cur_x, 24-bit with wrap, zero-extended to 32 bits.
  - vram_data_out_o = colour.
  - Address and data are held stable until vram_ack_i=1, then go to NEXT.
  - Wait for ack indefinitely; there is no timeout.
- **NEXT (one cycle, sel=0):**
  - If cur_x<x1: cur_x+1.
  - Else if cur_y<y1: cur_x=x0, cur_y+1, row_base+=FB_WIDTH.
  - Else go to FINISH.
  - Otherwise return to REQ.
- **FINISH:** done_o=1 for one cycle, then return to IDLE.
- busy_o=1 in every state except IDLE. cmd_ready_o equals IDLE.
- vram_ack_i is ignored outside REQ.
- cmd_valid_i is ignored while busy; the command is not queued.
- The counters are 16 bits. Because x1 ≤ FB_WIDTH-1 is guaranteed by the range policy, the counters never wrap.

## Timing
- Reset values (reset_n_i=0 at a clk edge): state IDLE, cmd_ready_o=0 during reset and 1 on the first cycle after, all other outputs 0.
- Reset mid-command aborts immediately: no done_o, sel drops on the next edge.
- Command accepted at edge N → SETUP in cycle N+1 → vram_sel_o=1 from cycle N+2.
- An ack in cycle M gives sel=0 in M+1 and the next request in M+2. Minimum is 2 cycles per pixel when ack returns in the same cycle as sel.
- After the last ack at cycle M: NEXT in M+1, done_o in M+2, cmd_ready_o=1 in M+3.
- Empty or rejected command accepted at N: done_o (or err_o) at N+2, and ready at N+3.

## Configuration
- RECT_FILL_CLIP_EN defined: x1 and y1 are clamped to FB_WIDTH-1 and FB_HEIGHT-1. If x0 ≥ FB_WIDTH or y0 ≥ FB_HEIGHT, the rectangle is empty (done_o, no writes). err_o is tied to 0.
- RECT_FILL_CLIP_EN undefined: if any coordinate is out of range, the command is rejected. The engine pulses err_o in the FINISH cycle instead of done_o and performs no writes. In-range commands behave identically to the clipped build.

## Structure
- Shared package rect_fill_pkg holds:
  - the state enum rect_fill_state_t;
  - the coordinate type coord_t (16-bit);
  - the address width constant VRAM_ADDR_W = 24;
  - the colour field offsets.
- No sub-module. The y0*FB_WIDTH product is a single registered multiply inside SETUP.

## Test plan
- Reset, then cmd (2,1)-(4,2) colour 16'h0F00 with ack in the same cycle as sel → 6 writes at addresses 642, 643, 644, 1282, 1283, 1284, all data 0F00 and mask F. done_o follows the last ack by 2 cycles.
- Same command with ack delayed 5 cycles per request → addr and data held stable across every wait. No write is skipped or duplicated.
- cmd (639,479)-(639,479) → a single write at address 307199.
- cmd (630,0)-(700,0):
  - with clipping: 10 writes (addr 630–639);
  - without clipping: err_o pulse, zero writes.
- cmd (5,5)-(3,5) → no writes, done_o at N+2.
- Reset asserted during the 3rd pending request → vram_sel_o=0 on the next edge and no done_o. A new command after reset completes normally. cmd_valid_i asserted while busy is never accepted.
